// File: rtl/hpu_pkg.sv
// Shared types and default sizing for the HPU trigger-event path.
// No ports; imported by hpu_trig_evt_arb.
package hpu_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } trig_arb_st_e;

  localparam int TRIG_CH_NUM    = 4;
  localparam int TRIG_EVT_DEPTH = 4;
  localparam int TRIG_EVT_DW    = 32;

endpackage

// File: rtl/hpu_trig_evt_fifo.sv
// One DEPTH x DATA_W event FIFO with synchronous flush.
// Ports: clk_i/rst_ni, flush_i, push_i/data_i, pop_i/head_o, full_o, empty_o, lvl_o.
module hpu_trig_evt_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       lvl_o
);

  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign lvl_o   = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/hpu_trig_evt_arb.sv
// Multi-channel trigger-event collector: per-channel FIFOs merged by a
// round-robin arbiter into one valid/ready stream. Ports: clk_i, rst_ni,
// evt_vld_i/evt_data_i/evt_rdy_o (per channel), out_vld_o/out_data_o/
// out_ch_o/out_rdy_i, flush_i, ch_lvl_o. Option: HPU_TRIG_CH0_PRIO_EN
// makes channel 0 strict priority.
module hpu_trig_evt_arb
  import hpu_pkg::*;
#(
  parameter int CH_NUM  = TRIG_CH_NUM,
  parameter int DEPTH   = TRIG_EVT_DEPTH,
  parameter int DATA_W  = TRIG_EVT_DW,
  localparam int CH_W   = $clog2(CH_NUM),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CH_NUM-1:0]        evt_vld_i,
  input  logic [CH_NUM*DATA_W-1:0] evt_data_i,
  output logic [CH_NUM-1:0]        evt_rdy_o,
  output logic                     out_vld_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  input  logic                     out_rdy_i,
  input  logic                     flush_i,
  output logic [CH_NUM*LW-1:0]     ch_lvl_o
);

  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] empty;
  logic [CH_NUM-1:0] push;
  logic [CH_NUM-1:0] pop;
  logic [DATA_W-1:0] head [CH_NUM];

  trig_arb_st_e    st_q, st_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] hold_q, hold_d;
  logic [CH_W-1:0] srch;
  logic [CH_W-1:0] grant;
  logic            vld;
  logic            hs;

  assign evt_rdy_o = ~full & {CH_NUM{~flush_i}};
  assign push      = evt_vld_i & evt_rdy_o;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    hpu_trig_evt_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[k]),
      .data_i  (evt_data_i[k*DATA_W +: DATA_W]),
      .pop_i   (pop[k]),
      .head_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .lvl_o   (ch_lvl_o[k*LW +: LW])
    );
  end

  // First non-empty channel at or above rr, wrapping.
  always_comb begin
    logic            found;
    logic [CH_W-1:0] ci;
    srch  = '0;
    found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      ci = CH_W'((int'(rr_q) + i) % CH_NUM);
      if (!found && !empty[ci]) begin
        srch  = ci;
        found = 1'b1;
      end
    end
`ifdef HPU_TRIG_CH0_PRIO_EN
    if (!empty[0]) srch = '0;
`endif
  end

  assign grant = (st_q == HOLD) ? hold_q : srch;
  assign vld   = (st_q == HOLD) || !(&empty);
  assign hs    = vld && out_rdy_i && !flush_i;

  assign out_vld_o  = vld;
  assign out_data_o = vld ? head[grant] : '0;
  assign out_ch_o   = vld ? grant : '0;

  always_comb begin
    pop = '0;
    if (hs) pop[grant] = 1'b1;
  end

  always_comb begin
    st_d   = st_q;
    rr_d   = rr_q;
    hold_d = hold_q;
    unique case (st_q)
      ARB: begin
        if (vld && !out_rdy_i) begin
          st_d   = HOLD;
          hold_d = srch;
        end
      end
      HOLD: begin
        if (out_rdy_i) st_d = ARB;
      end
      default: st_d = ARB;
    endcase
    if (hs) begin
      rr_d = (grant == CH_W'(CH_NUM - 1)) ? '0 : grant + CH_W'(1);
`ifdef HPU_TRIG_CH0_PRIO_EN
      // Channel 0 bypasses the rotation, so it must not disturb it.
      if (grant == '0) rr_d = rr_q;
`endif
    end
    if (flush_i) begin
      st_d   = ARB;
      rr_d   = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ARB;
      rr_q   <= '0;
      hold_q <= '0;
    end else begin
      st_q   <= st_d;
      rr_q   <= rr_d;
      hold_q <= hold_d;
    end
  end

endmodule
